// File: rtl/fifo_pkt_writer.sv
// fifo_pkt_writer: write-side packet framer for the 32-bit dual-clock FIFO.
// Emits header / generated payload / XOR-checksum trailer words, honours
// fifo_full back-pressure, and keeps packet and overflow-error counters.
module fifo_pkt_writer #(
    parameter logic [7:0]  SYNC_WORD = 8'hA5,
    parameter logic [31:0] LFSR_TAPS = 32'h80200003
) (
    input  logic        wclk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_len,
    input  logic [31:0] cmd_seed,
    input  logic        cmd_mode,
    output logic [31:0] fifo_wr_data,
    output logic        fifo_wr_en,
    input  logic        fifo_full,
    input  logic        fifo_wr_err,
    output logic        busy,
    output logic        pkt_done,
    output logic [15:0] pkt_cnt,
    output logic [7:0]  ovf_err_cnt
);

    typedef enum logic [1:0] {IDLE, HDR, PAY, TRL} state_t;

    // Command fields latched at accept; only seed and mode outlive the header.
    typedef struct packed {
        logic        mode;
        logic [31:0] seed;
    } cmd_t;

    state_t      state;
    cmd_t        cmd_q;
    logic [31:0] word_q;     // word currently presented to the FIFO
    logic [31:0] csum_q;     // XOR of all words already written this packet
    logic [7:0]  rem_q;      // payload words still to write (len at accept)

    logic        cmd_fire;
    logic [31:0] csum_nxt;
    logic [31:0] hdr_word;
    logic [31:0] seed_word;
    logic [31:0] next_word;

    assign cmd_ready    = (state == IDLE);
    assign busy         = (state != IDLE);
    // Combinational so a full flag raised this cycle blocks this cycle's write.
    assign fifo_wr_en   = busy && !fifo_full;
    assign fifo_wr_data = word_q;
    assign cmd_fire     = cmd_valid && cmd_ready;
    // Checksum including the word being written now; becomes the trailer.
    assign csum_nxt     = csum_q ^ word_q;

    // Header, first payload value and next payload value for the word register.
    always_comb begin
        hdr_word  = {SYNC_WORD, 7'd0, cmd_mode, pkt_cnt[7:0], cmd_len};
        // An all-zero LFSR state would lock up, so a zero seed becomes 1.
        seed_word = (cmd_q.mode && (cmd_q.seed == 32'd0)) ? 32'h1 : cmd_q.seed;
        if (cmd_q.mode)
            next_word = {word_q[30:0], ^(word_q & LFSR_TAPS)};
        else
            next_word = word_q + 32'd1;
    end

    // Packet FSM: accept, then advance one word per accepted FIFO write.
    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cmd_q    <= '0;
            word_q   <= '0;
            csum_q   <= '0;
            rem_q    <= '0;
            pkt_cnt  <= '0;
            pkt_done <= 1'b0;
        end else begin
            pkt_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_fire) begin
                        cmd_q.mode <= cmd_mode;
                        cmd_q.seed <= cmd_seed;
                        rem_q      <= cmd_len;
                        word_q     <= hdr_word;
                        csum_q     <= '0;
                        state      <= HDR;
                    end
                end
                HDR: begin
                    if (!fifo_full) begin
                        csum_q <= csum_nxt;
                        if (rem_q == 8'd0) begin
                            word_q <= csum_nxt;
                            state  <= TRL;
                        end else begin
                            word_q <= seed_word;
                            state  <= PAY;
                        end
                    end
                end
                PAY: begin
                    if (!fifo_full) begin
                        csum_q <= csum_nxt;
                        rem_q  <= rem_q - 8'd1;
                        if (rem_q == 8'd1) begin
                            word_q <= csum_nxt;
                            state  <= TRL;
                        end else begin
                            word_q <= next_word;
                        end
                    end
                end
                TRL: begin
                    if (!fifo_full) begin
                        pkt_cnt  <= pkt_cnt + 16'd1;
                        pkt_done <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Count cycles with the FIFO write-error flag raised, saturating at 255.
    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n)
            ovf_err_cnt <= '0;
        else if (fifo_wr_err && (ovf_err_cnt != 8'hFF))
            ovf_err_cnt <= ovf_err_cnt + 8'd1;
    end

endmodule

// File: tb/tb_fifo_pkt_writer.sv
// tb_fifo_pkt_writer: directed packets against a packet-level model
// (expected word queue built from the framing rules) plus literal checks.
module tb_fifo_pkt_writer;

    logic        wclk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_len;
    logic [31:0] cmd_seed;
    logic        cmd_mode;
    logic [31:0] fifo_wr_data;
    logic        fifo_wr_en;
    logic        fifo_full;
    logic        fifo_wr_err;
    logic        busy;
    logic        pkt_done;
    logic [15:0] pkt_cnt;
    logic [7:0]  ovf_err_cnt;

    fifo_pkt_writer dut (
        .wclk(wclk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .cmd_seed(cmd_seed), .cmd_mode(cmd_mode),
        .fifo_wr_data(fifo_wr_data), .fifo_wr_en(fifo_wr_en),
        .fifo_full(fifo_full), .fifo_wr_err(fifo_wr_err),
        .busy(busy), .pkt_done(pkt_done), .pkt_cnt(pkt_cnt),
        .ovf_err_cnt(ovf_err_cnt)
    );

    always #5 wclk = ~wclk;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } wr_t;

    int          n_cmp  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    int          m_pkts = 0;
    int          m_ovf  = 0;
    int          n_done = 0;
    logic [31:0] exp_q[$];
    wr_t         wr_log[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Packet-level model: the complete word sequence a command must produce.
    task automatic push_pkt(input logic [7:0] len, input logic [31:0] seed, input logic mode);
        logic [31:0] w, sum, hdr;
        hdr = {8'hA5, 7'd0, mode, m_pkts[7:0], len};
        exp_q.push_back(hdr);
        sum = hdr;
        w = (mode && seed == 0) ? 32'd1 : seed;
        for (int i = 0; i < len; i++) begin
            exp_q.push_back(w);
            sum ^= w;
            if (mode) w = {w[30:0], 1'($countones(w & 32'h80200003) % 2)};
            else      w = w + 1;
        end
        exp_q.push_back(sum);
    endtask

    always @(posedge wclk) cyc <= cyc + 1;

    // Error-counter model: saturating count of sampled error cycles.
    always @(posedge wclk or negedge rst_n) begin
        if (!rst_n)                         m_ovf <= 0;
        else if (fifo_wr_err && m_ovf < 255) m_ovf <= m_ovf + 1;
    end

    // Compare process: checks every write and the counters each cycle.
    always @(negedge wclk) begin
        logic [31:0] e;
        if (!rst_n) begin
            exp_q.delete();
            m_pkts = 0;
        end else begin
            if (fifo_wr_en && fifo_full) begin
                n_cmp++; n_fail++;
                $display("FAIL wr_into_full: wr_en=1 while fifo_full=1 (cycle %0d)", cyc);
            end
            if (fifo_wr_en) begin
                wr_log.push_back('{fifo_wr_data, cyc});
                if (exp_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_write: got %h expected no write (cycle %0d)", fifo_wr_data, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_data", fifo_wr_data, e);
                end
            end
            chk("ovf_err_cnt", {24'd0, ovf_err_cnt}, m_ovf[31:0]);
            if (pkt_done) begin
                m_pkts++;
                n_done++;
                chk("pkt_cnt", {16'd0, pkt_cnt}, m_pkts[31:0]);
            end
        end
    end

    // Wait until the writer is idle with nothing outstanding; ends at posedge+1.
    task automatic wait_idle();
        int n = 0;
        while (1) begin
            @(negedge wclk);
            if (cmd_ready && exp_q.size() == 0) break;
            if (++n > 2000) begin
                n_cmp++; n_fail++;
                $display("FAIL wait_idle_timeout: ready=%0b outstanding=%0d", cmd_ready, exp_q.size());
                break;
            end
        end
        @(posedge wclk); #1;
    endtask

    task automatic send(input logic [7:0] len, input logic [31:0] seed, input logic mode);
        wait_idle();
        push_pkt(len, seed, mode);
        cmd_len = len; cmd_seed = seed; cmd_mode = mode; cmd_valid = 1'b1;
        @(posedge wclk); #1;
        cmd_valid = 1'b0;
    endtask

    // Wait (bounded) until the log holds n entries; ends at posedge+1 of that write.
    task automatic wait_writes(input int n);
        int k = 0;
        while (wr_log.size() < n) begin
            @(posedge wclk); #1;
            if (++k > 2000) begin
                n_cmp++; n_fail++;
                $display("FAIL wait_writes_timeout: got %0d writes expected %0d", wr_log.size(), n);
                break;
            end
        end
    endtask

    task automatic chk_log(input string nm, input int base, input logic [31:0] w[]);
        chk({nm, "_count"}, wr_log.size() - base, w.size());
        for (int i = 0; i < w.size() && base + i < wr_log.size(); i++)
            chk(nm, wr_log[base+i].data, w[i]);
    endtask

    initial begin
        int base, d0;
        logic [31:0] lit[];
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_len = '0; cmd_seed = '0; cmd_mode = 1'b0;
        fifo_full = 1'b0; fifo_wr_err = 1'b0;

        // Reset state
        @(negedge wclk); @(negedge wclk);
        chk("rst_wr_en", fifo_wr_en, 0);
        chk("rst_wr_data", fifo_wr_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_done", pkt_done, 0);
        chk("rst_pkt_cnt", pkt_cnt, 0);
        chk("rst_ovf", ovf_err_cnt, 0);
        @(posedge wclk); #1 rst_n = 1'b1;

        // 1: incrementing packet
        base = wr_log.size(); d0 = n_done;
        send(3, 32'h10, 0);
        wait_idle();
        lit = '{32'hA5000003, 32'h10, 32'h11, 32'h12, 32'hA5000010};
        chk_log("t1_data", base, lit);
        if (wr_log.size() >= base + 5) chk("t1_span", wr_log[base+4].cyc - wr_log[base].cyc, 4);
        chk("t1_done_pulses", n_done - d0, 1);
        chk("t1_pkt_cnt", pkt_cnt, 1);

        // 2: empty LFSR packet, zero seed
        base = wr_log.size();
        send(0, 32'h0, 1);
        wait_idle();
        lit = '{32'hA5010100, 32'hA5010100};
        chk_log("t2_data", base, lit);
        chk("t2_pkt_cnt", pkt_cnt, 2);

        // 3: back-pressure after the 2nd payload word, with 32-bit wrap
        base = wr_log.size();
        send(4, 32'hFFFFFFFE, 0);
        wait_writes(base + 3);
        fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge wclk);
            chk("t3_stall_wr_en", fifo_wr_en, 0);
            chk("t3_stall_data", fifo_wr_data, 32'h0);
            @(posedge wclk); #1;
        end
        fifo_full = 1'b0;
        wait_idle();
        lit = '{32'hA5000204, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h1, 32'hA5000204};
        chk_log("t3_data", base, lit);
        if (wr_log.size() >= base + 6) chk("t3_span", wr_log[base+5].cyc - wr_log[base].cyc, 8);

        // 4: LFSR payload
        base = wr_log.size();
        send(3, 32'h1, 1);
        wait_idle();
        lit = '{32'hA5010303, 32'h1, 32'h3, 32'h6, 32'hA5010307};
        chk_log("t4_data", base, lit);

        // 5: reset mid-packet
        base = wr_log.size();
        send(5, 32'h100, 0);
        wait_writes(base + 3);
        rst_n = 1'b0;
        #1;
        chk("t5_wr_en", fifo_wr_en, 0);
        chk("t5_busy", busy, 0);
        chk("t5_ready", cmd_ready, 1);
        chk("t5_pkt_cnt", pkt_cnt, 0);
        repeat (2) @(posedge wclk);
        #1 rst_n = 1'b1;
        base = wr_log.size();
        send(1, 32'h55, 0);
        wait_idle();
        lit = '{32'hA5000001, 32'h55, 32'hA5000054};
        chk_log("t5_data", base, lit);
        if (wr_log.size() > base) chk("t5_seq", {24'd0, wr_log[base].data[15:8]}, 0);
        chk("t5_pkt_cnt_after", pkt_cnt, 1);

        // 6: error counter saturation, commands ignored while busy
        wait_idle();
        base = wr_log.size(); d0 = n_done;
        fifo_wr_err = 1'b1;
        repeat (100) @(posedge wclk);
        #1 chk("t6_ovf_100", ovf_err_cnt, 100);
        for (int i = 0; i < 200; i++) begin
            if (i == 0) begin
                push_pkt(2, 32'h7, 0);
                cmd_len = 2; cmd_seed = 32'h7; cmd_mode = 0; cmd_valid = 1'b1;
            end
            if (i == 1) cmd_valid = 1'b0;
            if (i == 2) begin
                cmd_len = 9; cmd_seed = 32'h99; cmd_mode = 1; cmd_valid = 1'b1;
            end
            if (i == 4) cmd_valid = 1'b0;
            @(posedge wclk); #1;
        end
        chk("t6_ovf_sat", ovf_err_cnt, 255);
        fifo_wr_err = 1'b0;
        wait_idle();
        repeat (5) @(posedge wclk);
        #1;
        chk("t6_writes", wr_log.size() - base, 4);
        chk("t6_done_pulses", n_done - d0, 1);
        chk("t6_pkt_cnt", pkt_cnt, 2);
        chk("t6_ready", cmd_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_pkt_writer.md
Name: fifo_pkt_writer

Overview:
Write-side packet source for the 32-bit dual-clock FIFO, running entirely in the wclk domain. It accepts a packet command through a valid/ready handshake and emits one framed packet into the FIFO write port. Each packet is a header word, then 0..255 generated payload words, then an XOR checksum trailer. It honours fifo_full back-pressure, so no write is ever attempted into a full FIFO. It also keeps packet and overflow-error counters for the read-side checker and for debug.

Parameters:
SYNC_WORD, 8'hA5, value placed in header bits [31:24]; the read side resynchronises on it.
LFSR_TAPS, 32'h80200003, feedback mask for polynomial x^32+x^22+x^2+x+1 (bits 31, 21, 1, 0).

Ports:
wclk  input  1  write-domain clock; all logic is on its rising edge.
rst_n  input  1  asynchronous, active-low reset.
cmd_valid  input  1  packet command valid.
cmd_ready  output  1  writer can accept a command; equals (state==IDLE).
cmd_len  input  8  payload word count, 0..255.
cmd_seed  input  32  first payload value.
cmd_mode  input  1  0 = incrementing payload, 1 = LFSR payload.
fifo_wr_data  output  32  word to FIFO.
fifo_wr_en  output  1  FIFO write strobe.
fifo_full  input  1  FIFO full, combinational from FIFO.
fifo_wr_err  input  1  FIFO write-error flag.
busy  output  1  state != IDLE.
pkt_done  output  1  one-cycle pulse after the trailer is written.
pkt_cnt  output  16  packets completed; wraps at 16 bits.
ovf_err_cnt  output  8  cycles with fifo_wr_err high; saturates at 255.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE, so cmd_ready = 1.
  - fifo_wr_en = 0, fifo_wr_data = 0, busy = 0, pkt_done = 0, pkt_cnt = 0, ovf_err_cnt = 0.
  - All internal registers (word register, remaining count, checksum, latched mode) = 0.
- States: IDLE, HDR, PAY, TRL.
- IDLE:
  - Command accepted on the edge where cmd_valid && cmd_ready.
  - Latch len and mode; load the word register with the header; checksum = 0; go to HDR.
  - cmd_valid while not IDLE is ignored; the command is not queued.
- Header word layout:
  - [31:24] = SYNC_WORD.
  - [23:17] = 0.
  - [16] = mode.
  - [15:8] = pkt_cnt[7:0] (sequence number).
  - [7:0] = len.
- Write strobe:
  - fifo_wr_en = (state in {HDR, PAY, TRL}) && !fifo_full. This is combinational so the FIFO's same-cycle full decision is respected.
  - fifo_wr_data = word register, driven directly from it.
  - The FIFO takes the word on the wclk edge where fifo_wr_en = 1.
- Advancing on each write edge:
  - checksum ^= fifo_wr_data.
  - HDR: if len==0 go to TRL; else load seed (mode 1 with seed==0 loads 32'h1) and go to PAY.
  - PAY: decrement remaining count. On the last payload word go to TRL; otherwise load the next word.
  - Next word, mode 0: word + 1, modulo 2^32.
  - Next word, mode 1: {w[30:0], ^(w & LFSR_TAPS)}.
  - TRL: the trailer word is the checksum accumulated before it (XOR of header and all payload words). After the write, go to IDLE, pkt_cnt += 1, and pkt_done is high for the next cycle.
- Stalls: while fifo_full, fifo_wr_en = 0. Word register, state, counters and checksum all hold; no word is skipped or duplicated.
- Latency and throughput:
  - First write is possible in the cycle after accept.
  - With no stalls, a packet occupies exactly len+2 consecutive wr_en cycles.
  - cmd_ready returns high in the cycle after the trailer write, so back-to-back packets have a 1-cycle gap.
- ovf_err_cnt increments on every wclk edge where fifo_wr_err = 1, saturating at 255. In correct operation it stays 0.
- Reset mid-packet: the partial packet is abandoned and all state is cleared. The next packet carries sequence 0; the read side discards the partial packet until the next SYNC_WORD.

Test Plan:
1. Incrementing packet: after reset, cmd len=3, mode=0, seed=0x10, fifo_full=0 -> 5 consecutive wr_en cycles with data 0xA5000003, 0x10, 0x11, 0x12, 0xA5000010. pkt_done pulses once; pkt_cnt=1.
2. Empty LFSR packet: next cmd len=0, mode=1, seed=0 -> data 0xA5010100, then trailer 0xA5010100; pkt_cnt=2.
3. Back-pressure: cmd len=4, mode=0, seed=0xFFFFFFFE; hold fifo_full=1 for 3 cycles after the 2nd payload word -> wr_en low for 3 cycles. Data holds 0x00000000 during the stall; payload sequence is FFFFFFFE, FFFFFFFF, 0, 1 (wrap); 6 writes total.
4. LFSR sequence: cmd len=3, mode=1, seed=1 -> payload 0x00000001, 0x00000003, 0x00000006; trailer equals the XOR of header and payload.
5. Reset mid-packet: pull rst_n low after the 2nd payload write -> wr_en=0, busy=0, cmd_ready=1. After release, a new cmd len=1 gives header sequence byte 0x00 and pkt_cnt=1 after completion.
6. Error counter: hold fifo_wr_err high for 300 cycles -> ovf_err_cnt counts up and saturates at 255; cmd_valid pulsed while busy -> no extra packet.
